// File: rtl/cache_line_adaptor_pkg.sv
// Shared types and sizes for the cache-line to burst-memory adaptor.
package cache_line_adaptor_pkg;

  localparam int unsigned LINE_W    = 256;
  localparam int unsigned BURST_W   = 64;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned NUM_BEATS = LINE_W / BURST_W;
  localparam int unsigned BEAT_W    = $clog2(NUM_BEATS);

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] burst_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_line_adaptor.sv
// cache_line_adaptor: turns one 256-bit cache-line read/write into a
// four-beat 64-bit memory burst and returns a single-cycle completion pulse.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   read_i, write_i      cache request levels (read wins if both high)
//   address_i, line_i    cache line address / write data
//   line_o, resp_o       assembled read line / completion pulse
//   read_o, write_o      memory request
//   address_o            memory address, held for the whole burst
//   burst_o, burst_i     write beat out / read beat in
//   resp_i               memory beat valid/accept strobe
//
// Optional build macro: CACHE_LINE_ADAPTOR_ASSERT_EN compiles in
// simulation-only protocol assertions; behaviour is identical without it.
module cache_line_adaptor
  import cache_line_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  output logic                resp_o,
  output logic                read_o,
  output logic                write_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [BURST_W-1:0]  burst_o,
  input  logic [BURST_W-1:0]  burst_i,
  input  logic                resp_i
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_e              state_q;
  state_e              state_d;
  logic [BEAT_W-1:0]   beat_q;
  burst_t              beats_q [NUM_BEATS];
  line_t               rd_line;
  logic                last_beat;

  assign last_beat = resp_i && (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
        end else if (write_i) begin
          state_d = WRITE;
        end
      end
      READ:    if (last_beat) state_d = DONE;
      WRITE:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completed read line: beats 0..2 from the buffer, beat 3 straight off the bus
  always_comb begin
    rd_line = '0;
    for (int unsigned k = 0; k < NUM_BEATS - 1; k++) begin
      rd_line[k*BURST_W +: BURST_W] = beats_q[k];
    end
    rd_line[LINE_W-BURST_W +: BURST_W] = burst_i;
  end

  // Write beat mux; zero outside WRITE so nothing leaks onto the bus
  always_comb begin
    burst_o = '0;
    if (state_q == WRITE) begin
      burst_o = beats_q[beat_q];
    end
  end

  // Datapath and registered request/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      line_o    <= '0;
      beat_q    <= '0;
      for (int unsigned k = 0; k < NUM_BEATS; k++) begin
        beats_q[k] <= '0;
      end
    end else begin
      read_o  <= (state_d == READ);
      write_o <= (state_d == WRITE);
      resp_o  <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (read_i) begin
            address_o <= address_i;
            beat_q    <= '0;
          end else if (write_i) begin
            address_o <= address_i;
            beat_q    <= '0;
            for (int unsigned k = 0; k < NUM_BEATS; k++) begin
              beats_q[k] <= line_i[k*BURST_W +: BURST_W];
            end
          end
        end
        READ: begin
          if (resp_i) begin
            beats_q[beat_q] <= burst_i;
            beat_q          <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              line_o <= rd_line;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_LINE_ADAPTOR_ASSERT_EN
  // Protocol checks, simulation only
  a_req_excl: assert property (@(posedge clk) disable iff (rst)
    !(read_i && write_i))
    else $error("read_i and write_i high together");
  a_mem_excl: assert property (@(posedge clk) disable iff (rst)
    !(read_o && write_o))
    else $error("read_o and write_o high together");
  a_resp_pulse: assert property (@(posedge clk) disable iff (rst)
    resp_o |=> !resp_o)
    else $error("resp_o high for more than one cycle");
  a_idle_resp: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !resp_i)
    else $error("resp_i seen while idle");
`else
  // Assertions not compiled in.
`endif

endmodule

// File: tb/tb_cache_line_adaptor.sv
// Directed/self-checking bench for cache_line_adaptor.
module tb_cache_line_adaptor;
  import cache_line_adaptor_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   read_i, write_i, resp_i;
  addr_t  address_i;
  line_t  line_i;
  line_t  line_o;
  logic   resp_o, read_o, write_o;
  addr_t  address_o;
  burst_t burst_o, burst_i;

  int errors = 0;
  int checks = 0;

  cache_line_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read of 'data' at 'a'; pat bit i (LSB first) drives resp_i in cycle i.
  task automatic do_read(input addr_t a, input line_t data, input logic [63:0] pat,
                         output int cycles);
    int beat;
    int i;
    @(negedge clk);
    read_i = 1'b1; address_i = a;
    @(negedge clk);
    read_i = 1'b0; address_i = ~a;
    beat = 0; i = 0; cycles = 0;
    while (beat < 4 && i < 64) begin
      check("rd_read_o", LINE_W'(read_o), LINE_W'(1'b1));
      check("rd_resp_o", LINE_W'(resp_o), '0);
      check("rd_addr", LINE_W'(address_o), LINE_W'(a));
      check("rd_excl", LINE_W'(read_o & write_o), '0);
      resp_i  = pat[i];
      burst_i = pat[i] ? data[beat*BURST_W +: BURST_W] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[i]) beat++;
      i++; cycles++;
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    check("rd_beats", LINE_W'(beat), LINE_W'(4));
    check("rd_done_resp", LINE_W'(resp_o), LINE_W'(1'b1));
    check("rd_done_read", LINE_W'(read_o), '0);
    check("rd_line", line_o, data);
    @(negedge clk);
    check("rd_pulse_end", LINE_W'(resp_o), '0);
    check("rd_line_hold", line_o, data);
  endtask

  task automatic do_write(input addr_t a, input line_t data, input logic [63:0] pat);
    int beat;
    int i;
    @(negedge clk);
    write_i = 1'b1; address_i = a; line_i = data;
    @(negedge clk);
    write_i = 1'b0; address_i = ~a; line_i = ~data;
    beat = 0; i = 0;
    while (beat < 4 && i < 64) begin
      check("wr_write_o", LINE_W'(write_o), LINE_W'(1'b1));
      check("wr_resp_o", LINE_W'(resp_o), '0);
      check("wr_addr", LINE_W'(address_o), LINE_W'(a));
      check("wr_excl", LINE_W'(read_o & write_o), '0);
      check("wr_burst", LINE_W'(burst_o), LINE_W'(data[beat*BURST_W +: BURST_W]));
      resp_i = pat[i];
      if (pat[i]) beat++;
      i++;
      @(negedge clk);
    end
    resp_i = 1'b0;
    check("wr_beats", LINE_W'(beat), LINE_W'(4));
    check("wr_done_write", LINE_W'(write_o), '0);
    check("wr_done_resp", LINE_W'(resp_o), LINE_W'(1'b1));
    @(negedge clk);
    check("wr_pulse_end", LINE_W'(resp_o), '0);
  endtask

  initial begin
    line_t d;
    int    cyc;
    int    w;
    addr_t a;

    rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'hFFFF_FFFF; line_i = '0; burst_i = '0;

    // Reset held with a pending read: nothing may assert
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst_read_o", LINE_W'(read_o), '0);
      check("rst_write_o", LINE_W'(write_o), '0);
      check("rst_resp_o", LINE_W'(resp_o), '0);
    end
    rst = 1'b0; read_i = 1'b0;
    @(negedge clk);
    check("idle_addr", LINE_W'(address_o), '0);
    check("idle_line", line_o, '0);
    check("idle_burst", LINE_W'(burst_o), '0);
    check("idle_read_o", LINE_W'(read_o), '0);

    // Read with 7 wait cycles then 4 back-to-back beats
    d = {64'hDEAD_BEEF_0000_00A3, 64'hDEAD_BEEF_0000_00A2,
         64'hDEAD_BEEF_0000_00A1, 64'hDEAD_BEEF_0000_00A0};
    do_read(32'h1234_5640, d, 64'h780, cyc);
    check("rd_len", LINE_W'(cyc), LINE_W'(11));

    // Write with zero wait
    d = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    do_write(32'h0000_1000, d, 64'hF);
    check("wr_line_o_untouched", line_o,
          {64'hDEAD_BEEF_0000_00A3, 64'hDEAD_BEEF_0000_00A2,
           64'hDEAD_BEEF_0000_00A1, 64'hDEAD_BEEF_0000_00A0});

    // Gapped beats 1,0,0,1,1,0,1
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'hABCD_0040, d, 64'h59, cyc);
    check("gap_len", LINE_W'(cyc), LINE_W'(7));

    // Random reads then random writes
    for (int n = 0; n < 50; n++) begin
      a = $urandom;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      w = $urandom_range(0, 31);
      do_read(a, d, 64'hF << w, cyc);
    end
    for (int n = 0; n < 50; n++) begin
      a = $urandom;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      w = $urandom_range(0, 31);
      do_write(a, d, 64'hF << w);
    end

    // Reset after beat 2 of a read, then a clean read
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h5555_0000;
    @(negedge clk);
    read_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1; burst_i = 64'hCAFE_0000_0000_0000 | 64'(k);
      @(negedge clk);
    end
    resp_i = 1'b0;
    check("mid_read_o", LINE_W'(read_o), LINE_W'(1'b1));
    rst = 1'b1;
    #1;
    check("abort_read_o", LINE_W'(read_o), '0);
    check("abort_write_o", LINE_W'(write_o), '0);
    check("abort_resp_o", LINE_W'(resp_o), '0);
    check("abort_addr", LINE_W'(address_o), '0);
    check("abort_line", line_o, '0);
    @(negedge clk);
    rst = 1'b0;
    d = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
         64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
    do_read(32'h7777_0080, d, 64'h3C, cyc);
    check("post_rst_len", LINE_W'(cyc), LINE_W'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
